game_controller: RTL and testbench
==================================

GAME_CONTROLLER -- requirements
Module: game_controller

Interface
REQ-001 Parameter DEATH_FRAMES, default 60: frame ticks spent in DYING before OVER (legal 1..255).
REQ-002 Parameter AUTO_RESTART_FRAMES, default 30: frame ticks spent in OVER before auto-restart in AI mode (legal 1..255).
REQ-003 clk  input  1  system clock; the block's single clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 fps_tick  input  1  one-clk-cycle frame pulse; all game decisions are taken only on cycles where it is high.
REQ-006 key_jump  input  1  keyboard jump request, one or more clk cycles, asynchronous to fps_tick.
REQ-007 ql_jump  input  1  Q-learning jump decision, level, sampled on fps_tick.
REQ-008 ai_mode  input  1  1 = Q-learning drives the bird, 0 = keyboard (switch level).
REQ-009 is_collide  input  1  collision flag from collision detection, sampled on fps_tick.
REQ-010 current_score  input  7  live score from pipe logic.
REQ-011 state  output  2  IDLE=0, PLAY=1, DYING=2, OVER=3.
REQ-012 run_en  output  1  world (pipes, background, gravity) may advance this frame.
REQ-013 jump_out  output  1  arbitrated jump, held constant from one fps_tick to the next.
REQ-014 game_rst  output  1  one-clk pulse that re-initialises bird, pipes and score.
REQ-015 high_score  output  7  best score since reset.
REQ-016 episodes  output  8  completed games since reset, wraps 255->0.

Function
REQ-017 All outputs SHALL be registered; state changes SHALL occur only on clk edges where fps_tick=1, except game_rst clearing and pending-flag updates.
REQ-018 A pending flag SHALL set on any clk cycle with key_jump=1 and SHALL clear on every fps_tick, regardless of state (key_jump and fps_tick together: the press is consumed by that tick).
REQ-019 IDLE: run_en=0, jump_out=0; at fps_tick go to PLAY if ai_mode=1, or if ai_mode=0 and pending (or key_jump) is set; the entry tick drives jump_out=1.
REQ-020 PLAY: run_en=1; at each fps_tick jump_out SHALL load ql_jump if ai_mode=1, else pending|key_jump.
REQ-021 PLAY with is_collide=1 at fps_tick: go to DYING, run_en=0, jump_out=0, load the frame counter with DEATH_FRAMES-1; collision SHALL take priority over jump.
REQ-022 DYING: decrement the counter per fps_tick; at 0 go to OVER, increment episodes, load the counter with AUTO_RESTART_FRAMES-1.
REQ-023 OVER, ai_mode=0: an fps_tick with pending|key_jump SHALL pulse game_rst for exactly one clk and go to IDLE.
REQ-024 OVER, ai_mode=1: decrement per fps_tick; at 0 pulse game_rst and go to IDLE, then PLAY on the next tick.
REQ-025 A change of ai_mode seen at fps_tick in PLAY, DYING or OVER SHALL pulse game_rst and go to IDLE, without incrementing episodes; in IDLE it has no effect.
REQ-026 The counter is 8 bits; it SHALL never underflow (it holds at 0 until the transition).

Reset
REQ-027 rst=1 at any clk edge, including mid-DYING or OVER, SHALL force state=IDLE, run_en=0, jump_out=0, game_rst=0, pending=0, counter=0, high_score=0, episodes=0; rst SHALL take priority over fps_tick.

Configuration
REQ-028 Macro GAME_CTRL_HISCORE_EN defined: on the DYING->OVER transition, high_score SHALL load current_score if it is strictly greater.
REQ-029 Macro GAME_CTRL_HISCORE_EN undefined: no high-score register; high_score SHALL be constant 0.

Structure
REQ-030 A shared package SHALL hold the 2-bit game-state enum, the state encodings, and the score width constant (7).
REQ-031 A sub-module frame_counter (loadable 8-bit down-counter, tick-enabled, holds at 0) SHALL be used for the DYING and OVER timing; the rest stays in game_controller.

Verification
REQ-032 Reset, ai_mode=0, key_jump pulse, next fps_tick -> state=PLAY, run_en=1, jump_out=1 for one frame, then 0 on the following tick with no key.
REQ-033 PLAY, is_collide=1 with key_jump on the same tick -> DYING, jump_out=0; after 60 ticks -> OVER, episodes=1.
REQ-034 GAME_CTRL_HISCORE_EN defined, scores 5 then 3 on two deaths -> high_score=5 after both; macro undefined -> high_score=0 throughout.
REQ-035 ai_mode=1 death -> OVER, 30 ticks later game_rst is high for exactly 1 clk, IDLE, next tick PLAY with jump_out=ql_jump.
REQ-036 ai_mode toggled mid-PLAY -> game_rst pulse, IDLE, episodes unchanged; rst asserted mid-DYING -> all outputs at their reset values on the next clk.
REQ-037 256 completed episodes -> episodes wraps to 0.

Source files
------------

// File: rtl/game_controller_pkg.sv
// Shared game-state encoding, score width and frame-counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_controller_pkg;

  localparam int SCORE_W = 7;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PLAY  = 2'd1,
    ST_DYING = 2'd2,
    ST_OVER  = 2'd3
  } game_state_t;

endpackage

// File: rtl/game_controller_frame_counter.sv
// Loadable 8-bit down-counter, decremented on frame ticks, holds at zero.
// Latency: load or decrement is visible one clk after the enabling edge.
// Backpressure: none; load wins over tick, rst wins over both.
module frame_counter
  import game_controller_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  // Count down one per tick; never wraps below zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/game_controller.sv
// Game flow FSM: IDLE/PLAY/DYING/OVER, jump arbitration, episode and high-score tracking.
// Latency: every output is registered; decisions land one clk after the fps_tick edge.
// Backpressure: none; optional high-score register enabled by GAME_CTRL_HISCORE_EN.
module game_controller
  import game_controller_pkg::*;
#(
  parameter int DEATH_FRAMES        = 60,
  parameter int AUTO_RESTART_FRAMES = 30
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fps_tick,
  input  logic               key_jump,
  input  logic               ql_jump,
  input  logic               ai_mode,
  input  logic               is_collide,
  input  logic [SCORE_W-1:0] current_score,
  output logic [1:0]         state,
  output logic               run_en,
  output logic               jump_out,
  output logic               game_rst,
  output logic [SCORE_W-1:0] high_score,
  output logic [7:0]         episodes
);

  // Counter values are "frames left minus one": the transition fires on the tick that sees zero.
  localparam logic [CNT_W-1:0] DEATH_LOAD = CNT_W'(DEATH_FRAMES - 1);
  localparam logic [CNT_W-1:0] OVER_LOAD  = CNT_W'(AUTO_RESTART_FRAMES - 1);

  game_state_t      state_q, state_d;
  logic             run_en_q, run_en_d;
  logic             jump_q, jump_d;
  logic             game_rst_q, game_rst_d;
  logic             pending_q;
  logic             mode_q;
  logic [7:0]       episodes_q;
  logic             key_eff;
  logic             cnt_load;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;
  logic             ep_inc;

  frame_counter u_frame_counter (
    .clk      (clk),
    .rst      (rst),
    .tick     (fps_tick),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // Capture key presses between frames; each tick consumes them and samples the control mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q <= 1'b0;
      mode_q    <= 1'b0;
    end else if (fps_tick) begin
      pending_q <= 1'b0;
      mode_q    <= ai_mode;
    end else if (key_jump) begin
      pending_q <= 1'b1;
    end
  end

  // Next-state and output decisions; only a frame tick moves anything, game_rst self-clears.
  always_comb begin
    state_d    = state_q;
    run_en_d   = run_en_q;
    jump_d     = jump_q;
    game_rst_d = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = DEATH_LOAD;
    ep_inc     = 1'b0;
    key_eff    = pending_q | key_jump;
    if (fps_tick) begin
      if ((state_q != ST_IDLE) && (ai_mode != mode_q)) begin
        // Switching driver mid-game abandons the game without counting it.
        state_d    = ST_IDLE;
        run_en_d   = 1'b0;
        jump_d     = 1'b0;
        game_rst_d = 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (ai_mode || key_eff) begin
              state_d  = ST_PLAY;
              run_en_d = 1'b1;
              // The AI follows its own decision on the first frame; a keyboard start is a jump.
              jump_d   = ai_mode ? ql_jump : 1'b1;
            end
          end
          ST_PLAY: begin
            if (is_collide) begin
              state_d  = ST_DYING;
              run_en_d = 1'b0;
              jump_d   = 1'b0;
              cnt_load = 1'b1;
              cnt_val  = DEATH_LOAD;
            end else begin
              run_en_d = 1'b1;
              jump_d   = ai_mode ? ql_jump : key_eff;
            end
          end
          ST_DYING: begin
            if (cnt_zero) begin
              state_d  = ST_OVER;
              ep_inc   = 1'b1;
              cnt_load = 1'b1;
              cnt_val  = OVER_LOAD;
            end
          end
          default: begin
            if (ai_mode ? cnt_zero : key_eff) begin
              state_d    = ST_IDLE;
              run_en_d   = 1'b0;
              jump_d     = 1'b0;
              game_rst_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // State and registered outputs; episodes wraps naturally at 8 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      run_en_q   <= 1'b0;
      jump_q     <= 1'b0;
      game_rst_q <= 1'b0;
      episodes_q <= '0;
    end else begin
      state_q    <= state_d;
      run_en_q   <= run_en_d;
      jump_q     <= jump_d;
      game_rst_q <= game_rst_d;
      if (ep_inc) begin
        episodes_q <= episodes_q + 8'd1;
      end
    end
  end

`ifdef GAME_CTRL_HISCORE_EN
  logic [SCORE_W-1:0] high_score_q;

  // Keep the best final score, judged as each death sequence completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      high_score_q <= '0;
    end else if (ep_inc && (current_score > high_score_q)) begin
      high_score_q <= current_score;
    end
  end

  assign high_score = high_score_q;
`else
  logic score_unused;
  assign score_unused = ^current_score;
  assign high_score   = '0;
`endif

  assign state    = state_q;
  assign run_en   = run_en_q;
  assign jump_out = jump_q;
  assign game_rst = game_rst_q;
  assign episodes = episodes_q;

endmodule

// File: tb/tb_game_controller.sv
// Bench for game_controller: directed scenarios plus randomized traffic against a frame-level model.
// Latency: model expects every output change one clk after the driving edge.
// Backpressure: n/a.
module tb_game_controller;

  localparam int DF = 60;
  localparam int AF = 30;
  localparam int S_IDLE  = 0;
  localparam int S_PLAY  = 1;
  localparam int S_DYING = 2;
  localparam int S_OVER  = 3;

  logic       clk = 1'b0;
  logic       rst, fps_tick, key_jump, ql_jump, ai_mode, is_collide;
  logic [6:0] current_score;
  logic [1:0] state;
  logic       run_en, jump_out, game_rst;
  logic [6:0] high_score;
  logic [7:0] episodes;

  always #5 clk = ~clk;

  game_controller #(.DEATH_FRAMES(DF), .AUTO_RESTART_FRAMES(AF)) dut (
    .clk           (clk),
    .rst           (rst),
    .fps_tick      (fps_tick),
    .key_jump      (key_jump),
    .ql_jump       (ql_jump),
    .ai_mode       (ai_mode),
    .is_collide    (is_collide),
    .current_score (current_score),
    .state         (state),
    .run_en        (run_en),
    .jump_out      (jump_out),
    .game_rst      (game_rst),
    .high_score    (high_score),
    .episodes      (episodes)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: game phase plus "frames still to wait" in the current timed phase.
  int m_state, m_run, m_jump, m_grst, m_pend, m_prev_ai, m_left, m_games, m_hi;
  int hi_exp;
  int guard;

  task automatic check(input string tag, input int got, input int exp);
    tests_run++;
    if (got != exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int key_eff;
    if (rst) begin
      m_state = S_IDLE; m_run = 0; m_jump = 0; m_grst = 0; m_pend = 0;
      m_prev_ai = 0; m_left = 0; m_games = 0; m_hi = 0;
      return;
    end
    m_grst = 0;
    if (!fps_tick) begin
      if (key_jump) m_pend = 1;
      return;
    end
    key_eff = (m_pend != 0 || key_jump) ? 1 : 0;
    m_pend  = 0;
    if (m_state != S_IDLE && int'(ai_mode) != m_prev_ai) begin
      m_prev_ai = int'(ai_mode);
      m_state = S_IDLE; m_run = 0; m_jump = 0; m_grst = 1;
      return;
    end
    m_prev_ai = int'(ai_mode);
    case (m_state)
      S_IDLE: begin
        if (ai_mode || key_eff != 0) begin
          m_state = S_PLAY; m_run = 1;
          m_jump  = ai_mode ? int'(ql_jump) : 1;
        end
      end
      S_PLAY: begin
        if (is_collide) begin
          m_state = S_DYING; m_run = 0; m_jump = 0; m_left = DF;
        end else begin
          m_jump = ai_mode ? int'(ql_jump) : key_eff;
        end
      end
      S_DYING: begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_state = S_OVER;
          m_games = m_games + 1;
          m_left  = AF;
`ifdef GAME_CTRL_HISCORE_EN
          if (int'(current_score) > m_hi) m_hi = int'(current_score);
`endif
        end
      end
      default: begin
        if (ai_mode) begin
          m_left = m_left - 1;
          if (m_left == 0) begin
            m_state = S_IDLE; m_grst = 1;
          end
        end else if (key_eff != 0) begin
          m_state = S_IDLE; m_grst = 1;
        end
      end
    endcase
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    check("state",      int'(state),      m_state);
    check("run_en",     int'(run_en),     m_run);
    check("jump_out",   int'(jump_out),   m_jump);
    check("game_rst",   int'(game_rst),   m_grst);
    check("high_score", int'(high_score), m_hi);
    check("episodes",   int'(episodes),   m_games % 256);
  endtask

  task automatic do_tick();
    fps_tick = 1'b1;
    cycle();
    fps_tick = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      do_tick();
      cycle();
    end
  endtask

  initial begin
`ifdef GAME_CTRL_HISCORE_EN
    hi_exp = 5;
`else
    hi_exp = 0;
`endif
    rst = 1'b1; fps_tick = 1'b0; key_jump = 1'b0; ql_jump = 1'b0;
    ai_mode = 1'b0; is_collide = 1'b0; current_score = '0;
    repeat (3) cycle();
    check("rst_state", int'(state), S_IDLE);
    check("rst_run_en", int'(run_en), 0);
    check("rst_episodes", int'(episodes), 0);
    rst = 1'b0;
    cycle();

    // Keyboard start from a pulse that arrives between ticks
    key_jump = 1'b1; cycle(); key_jump = 1'b0; cycle(); cycle();
    do_tick();
    check("kb_start_state", int'(state), S_PLAY);
    check("kb_start_run", int'(run_en), 1);
    check("kb_start_jump", int'(jump_out), 1);
    cycle();
    do_tick();
    check("kb_nokey_jump", int'(jump_out), 0);
    cycle();

    // Collision beats a simultaneous jump; death lasts DF ticks
    current_score = 7'd5; is_collide = 1'b1; key_jump = 1'b1;
    do_tick();
    is_collide = 1'b0; key_jump = 1'b0;
    check("die_state", int'(state), S_DYING);
    check("die_jump", int'(jump_out), 0);
    cycle();
    tick_n(DF - 1);
    check("dying_hold", int'(state), S_DYING);
    do_tick();
    check("over_state", int'(state), S_OVER);
    check("over_eps", int'(episodes), 1);
    cycle();

    // Keyboard restart, second game with a lower score
    key_jump = 1'b1; do_tick(); key_jump = 1'b0;
    check("kb_rst_pulse", int'(game_rst), 1);
    check("kb_rst_idle", int'(state), S_IDLE);
    cycle();
    check("kb_rst_one_clk", int'(game_rst), 0);
    key_jump = 1'b1; do_tick(); key_jump = 1'b0;
    cycle();
    current_score = 7'd3; is_collide = 1'b1; do_tick(); is_collide = 1'b0;
    cycle();
    tick_n(DF);
    check("over2_eps", int'(episodes), 2);
    check("hiscore", int'(high_score), hi_exp);

    // Switch to AI while in OVER, then an AI game with auto-restart
    ai_mode = 1'b1; ql_jump = 1'b1;
    do_tick();
    check("mode_sw_rst", int'(game_rst), 1);
    check("mode_sw_idle", int'(state), S_IDLE);
    check("mode_sw_eps", int'(episodes), 2);
    cycle();
    do_tick();
    check("ai_start_state", int'(state), S_PLAY);
    cycle();
    is_collide = 1'b1; do_tick(); is_collide = 1'b0;
    cycle();
    tick_n(DF);
    check("ai_over_state", int'(state), S_OVER);
    tick_n(AF - 1);
    check("ai_over_hold", int'(state), S_OVER);
    do_tick();
    check("ai_auto_rst", int'(game_rst), 1);
    check("ai_auto_idle", int'(state), S_IDLE);
    cycle();
    check("ai_auto_rst_one_clk", int'(game_rst), 0);
    do_tick();
    check("ai_replay_state", int'(state), S_PLAY);
    check("ai_replay_jump", int'(jump_out), 1);
    cycle();

    // Mode toggle mid-PLAY, then reset in the middle of DYING
    ai_mode = 1'b0;
    do_tick();
    check("toggle_idle", int'(state), S_IDLE);
    check("toggle_rst", int'(game_rst), 1);
    check("toggle_eps", int'(episodes), 3);
    cycle();
    key_jump = 1'b1; do_tick(); key_jump = 1'b0;
    cycle();
    is_collide = 1'b1; do_tick(); is_collide = 1'b0;
    cycle();
    tick_n(10);
    rst = 1'b1; cycle(); rst = 1'b0;
    check("mid_rst_state", int'(state), S_IDLE);
    check("mid_rst_eps", int'(episodes), 0);
    check("mid_rst_hi", int'(high_score), 0);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rst           = ($urandom_range(0, 999) == 0);
      fps_tick      = ($urandom_range(0, 2) == 0);
      key_jump      = ($urandom_range(0, 9) == 0);
      ql_jump       = 1'($urandom_range(0, 1));
      is_collide    = ($urandom_range(0, 29) == 0);
      current_score = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 299) == 0) ai_mode = ~ai_mode;
      cycle();
    end

    // 256 back-to-back AI games: episode counter wraps
    rst = 1'b1; fps_tick = 1'b0; key_jump = 1'b0; cycle();
    rst = 1'b0; ai_mode = 1'b1; is_collide = 1'b1;
    guard = 0;
    while (m_games < 256 && guard < 30000) begin
      ql_jump = 1'($urandom_range(0, 1));
      do_tick();
      cycle();
      guard++;
    end
    check("wrap_episodes", int'(episodes), 0);
    check("wrap_state", int'(state), S_OVER);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
